// File: rtl/pic_usart_peripheral_pkg.sv
// Shared memory map, bit indices and state types for the USART peripheral.
package pic_usart_peripheral_pkg;

  localparam int ADDR_W     = 9;
  localparam int BAUD_CNT_W = 10;

  localparam logic [ADDR_W-1:0] ADDR_RCSTA = 9'h018;
  localparam logic [ADDR_W-1:0] ADDR_TXREG = 9'h019;
  localparam logic [ADDR_W-1:0] ADDR_RCREG = 9'h01A;
  localparam logic [ADDR_W-1:0] ADDR_TXSTA = 9'h098;
  localparam logic [ADDR_W-1:0] ADDR_SPBRG = 9'h099;

  localparam int TXSTA_TXEN = 5;
  localparam int TXSTA_BRGH = 2;
  localparam int TXSTA_TRMT = 1;

  localparam int RCSTA_SPEN = 7;
  localparam int RCSTA_CREN = 4;
  localparam int RCSTA_FERR = 2;
  localparam int RCSTA_OERR = 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Last count value of the tick divider: (SPBRG+1)*(BRGH ? 1 : 4) - 1.
  function automatic logic [BAUD_CNT_W-1:0] baud_terminal(input logic [7:0] spbrg,
                                                          input logic brgh);
    logic [BAUD_CNT_W:0] n;
    n = {3'b000, spbrg} + 11'd1;
    if (!brgh) n = n << 2;
    return BAUD_CNT_W'(n - 11'd1);
  endfunction

endpackage

// File: rtl/pic_usart_peripheral_if.sv
// Core-side peripheral bus into the USART register file.
interface pic_usart_peripheral_if;
  import pic_usart_peripheral_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              hit;

  modport master (output addr, wr_en, rd_en, data_in, input data_out, hit);
  modport slave  (input addr, wr_en, rd_en, data_in, output data_out, hit);
endinterface

// File: rtl/usart_baud_gen.sv
// Sub-bit tick generator: one-clock tick every (SPBRG+1)*(BRGH?1:4) clocks.
module usart_baud_gen
  import pic_usart_peripheral_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] spbrg,
  input  logic       brgh,
  input  logic       reload,
  output logic       tick
);

  logic [BAUD_CNT_W-1:0] cnt;
  logic [BAUD_CNT_W-1:0] term;

  assign term = baud_terminal(spbrg, brgh);
  assign tick = !reload && (cnt == term);

  // Free-running divider; >= catches a divisor shrinking under a live count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (reload || cnt >= term) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pic_usart_peripheral.sv
// PIC-style USART: register file, TX buffer/shifter and oversampled receiver.
module pic_usart_peripheral
  import pic_usart_peripheral_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2   // must be >= 2
)(
  input  logic                   clk,
  input  logic                   rst_n,
  pic_usart_peripheral_if.slave  bus,
  output logic                   txif_strobe,
  output logic                   rcif_strobe,
  input  logic                   uart_rxd,
  output logic                   uart_txd
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  // control / status
  logic [7:0] spbrg;
  logic       txen, brgh, trmt, spen, cren, ferr, oerr;

  // address decode
  logic sel_rcsta, sel_txreg, sel_rcreg, sel_txsta, sel_spbrg;
  logic wr_rcsta, wr_txreg, wr_txsta, wr_spbrg, rc_pop, cren_fall;
  logic tx_en, rx_en, tick;

  assign sel_rcsta = (bus.addr == ADDR_RCSTA);
  assign sel_txreg = (bus.addr == ADDR_TXREG);
  assign sel_rcreg = (bus.addr == ADDR_RCREG);
  assign sel_txsta = (bus.addr == ADDR_TXSTA);
  assign sel_spbrg = (bus.addr == ADDR_SPBRG);
  assign bus.hit   = sel_rcsta | sel_txreg | sel_rcreg | sel_txsta | sel_spbrg;

  assign wr_rcsta  = bus.wr_en & sel_rcsta;
  assign wr_txreg  = bus.wr_en & sel_txreg;
  assign wr_txsta  = bus.wr_en & sel_txsta;
  assign wr_spbrg  = bus.wr_en & sel_spbrg;
  assign rc_pop    = bus.rd_en & sel_rcreg;
  assign cren_fall = wr_rcsta & cren & ~bus.data_in[RCSTA_CREN];

  assign tx_en = spen & txen;
  assign rx_en = spen & cren;

  usart_baud_gen u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .spbrg  (spbrg),
    .brgh   (brgh),
    .reload (wr_spbrg),
    .tick   (tick)
  );

  // Writable control bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spbrg <= '0; txen <= 1'b0; brgh <= 1'b0; spen <= 1'b0; cren <= 1'b0;
    end else begin
      if (wr_spbrg) spbrg <= bus.data_in;
      if (wr_txsta) begin
        txen <= bus.data_in[TXSTA_TXEN];
        brgh <= bus.data_in[TXSTA_BRGH];
      end
      if (wr_rcsta) begin
        spen <= bus.data_in[RCSTA_SPEN];
        cren <= bus.data_in[RCSTA_CREN];
      end
    end
  end

  // ---------------- transmitter ----------------
  tx_state_e       tx_state;
  logic [7:0]      tx_buf, tx_sh;
  logic            tx_full, txd_q;
  logic [OS_W-1:0] tx_os;
  logic [2:0]      tx_bit;

  // TX FSM: a pending buffer moves into the shifter whenever the line is
  // idle or a stop bit ends, so consecutive bytes leave no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE; tx_buf <= '0; tx_full <= 1'b0; tx_sh <= '0;
      tx_os <= '0; tx_bit <= '0; txd_q <= 1'b1; trmt <= 1'b1; txif_strobe <= 1'b0;
    end else if (!tx_en) begin
      tx_state <= TX_IDLE; tx_full <= 1'b0; txd_q <= 1'b1; trmt <= 1'b1;
      txif_strobe <= 1'b0;
    end else begin
      txif_strobe <= 1'b0;
      case (tx_state)
        TX_IDLE: if (tx_full) begin
          tx_sh <= tx_buf; tx_full <= 1'b0; tx_os <= '0; tx_state <= TX_START;
          txd_q <= 1'b0; trmt <= 1'b0; txif_strobe <= 1'b1;
        end
        default: if (tick) begin
          if (tx_os != OS_LAST) tx_os <= tx_os + 1'b1;
          else begin
            tx_os <= '0;
            case (tx_state)
              TX_START: begin
                tx_state <= TX_DATA; tx_bit <= '0;
                txd_q <= tx_sh[0]; tx_sh <= tx_sh >> 1;
              end
              TX_DATA: if (tx_bit == 3'd7) begin
                tx_state <= TX_STOP; txd_q <= 1'b1;
              end else begin
                tx_bit <= tx_bit + 1'b1;
                txd_q <= tx_sh[0]; tx_sh <= tx_sh >> 1;
              end
              default: if (tx_full) begin
                tx_sh <= tx_buf; tx_full <= 1'b0; tx_state <= TX_START;
                txd_q <= 1'b0; txif_strobe <= 1'b1;
              end else begin
                tx_state <= TX_IDLE; trmt <= 1'b1;
              end
            endcase
          end
        end
      endcase
      // A write in the same cycle as a load refills the just-emptied buffer.
      if (wr_txreg) begin
        tx_buf <= bus.data_in; tx_full <= 1'b1;
      end
    end
  end

  assign uart_txd = txd_q | ~spen;

  // ---------------- receiver ----------------
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s, rx_prev;
  rx_state_e              rx_state;
  logic [7:0]             rx_sh, rcreg;
  logic                   rc_full;
  logic [OS_W-1:0]        rx_os;
  logic [2:0]             rx_bit;

  assign rx_s = rx_sync[SYNC_STAGES-1];

  // Metastability chain plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= '1; rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], uart_rxd};
      rx_prev <= rx_s;
    end
  end

  // RX FSM: start bit checked at half a bit, then every bit at its midpoint
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE; rx_sh <= '0; rcreg <= '0; rc_full <= 1'b0;
      rx_os <= '0; rx_bit <= '0; ferr <= 1'b0; oerr <= 1'b0; rcif_strobe <= 1'b0;
    end else begin
      rcif_strobe <= 1'b0;
      if (rc_pop) rc_full <= 1'b0;
      if (!rx_en) rx_state <= RX_IDLE;
      else begin
        case (rx_state)
          RX_IDLE: if (!oerr && rx_prev && !rx_s) begin
            rx_state <= RX_START; rx_os <= '0;
          end
          RX_START: if (tick) begin
            if (rx_os != OS_HALF) rx_os <= rx_os + 1'b1;
            else begin
              rx_os <= '0; rx_bit <= '0;
              rx_state <= rx_s ? RX_IDLE : RX_DATA;
            end
          end
          RX_DATA: if (tick) begin
            if (rx_os != OS_LAST) rx_os <= rx_os + 1'b1;
            else begin
              rx_os <= '0;
              rx_sh <= {rx_s, rx_sh[7:1]};
              if (rx_bit == 3'd7) rx_state <= RX_STOP;
              else                rx_bit <= rx_bit + 1'b1;
            end
          end
          default: if (tick) begin
            if (rx_os != OS_LAST) rx_os <= rx_os + 1'b1;
            else begin
              rx_state <= RX_IDLE; rx_os <= '0;
              // a pop in this same cycle frees the holding register first
              if (!rc_full || rc_pop) begin
                rcreg <= rx_sh; rc_full <= 1'b1; ferr <= ~rx_s; rcif_strobe <= 1'b1;
              end else begin
                oerr <= 1'b1;
              end
            end
          end
        endcase
      end
      if (cren_fall) oerr <= 1'b0;
    end
  end

  // ---------------- read mux ----------------
  logic [7:0] rd_data;

  // Read data for the addressed register; write-only TXREG reads as zero
  always_comb begin
    rd_data = '0;
    if (sel_rcsta) begin
      rd_data[RCSTA_SPEN] = spen;
      rd_data[RCSTA_CREN] = cren;
      rd_data[RCSTA_FERR] = ferr;
      rd_data[RCSTA_OERR] = oerr;
    end else if (sel_txsta) begin
      rd_data[TXSTA_TXEN] = txen;
      rd_data[TXSTA_BRGH] = brgh;
      rd_data[TXSTA_TRMT] = trmt;
    end else if (sel_rcreg) begin
      rd_data = rcreg;
    end else if (sel_spbrg) begin
      rd_data = spbrg;
    end
  end

  assign bus.data_out = rst_n ? rd_data : 8'h00;

endmodule

// File: tb/tb_pic_usart_peripheral.sv
// Self-checking bench: register vectors, directed TX/RX frames, randomized loopback.
module tb_pic_usart_peripheral;
  import pic_usart_peripheral_pkg::*;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd_drv = 1'b1;
  logic loop_en = 1'b0;
  logic txif_strobe, rcif_strobe, uart_rxd, uart_txd;

  int n_chk = 0, n_fail = 0;
  int n_txif = 0, n_rcif = 0, cyc = 0;

  pic_usart_peripheral_if bus();

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  pic_usart_peripheral #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .txif_strobe (txif_strobe),
    .rcif_strobe (rcif_strobe),
    .uart_rxd    (uart_rxd),
    .uart_txd    (uart_txd)
  );

  always #5 clk = ~clk;

  // strobe counters sample the cycle that just ended
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (txif_strobe) n_txif <= n_txif + 1;
    if (rcif_strobe) n_rcif <= n_rcif + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         wr;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic       exp_hit;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.data_in = d; bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [8:0] a, input logic [7:0] exp);
    bus.addr = a;
    #1;
    chk(nm, bus.data_out, exp);
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    @(negedge clk);
    bus.addr = ADDR_RCREG; bus.rd_en = 1'b1;
    #1;
    chk(nm, bus.data_out, exp);
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic apply_vecs(input int lo, input int hi, input string pfx);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      else            @(negedge clk);
      bus.addr = vecs[i].addr;
      #1;
      chk($sformatf("%s_hit%0d", pfx, i), bus.hit, vecs[i].exp_hit);
      chk($sformatf("%s_data%0d", pfx, i), bus.data_out, vecs[i].exp_data);
    end
  endtask

  // drive one serial frame on rxd (start, 8 data LSB first, stop, one idle bit)
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int per);
    rxd_drv = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (per) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (per) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (per) @(negedge clk);
  endtask

  // called on the first cycle of a start bit; checks each bit's first and last cycle
  task automatic tx_frame(input logic [7:0] b, input string nm);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_b%0d_first", nm, k), uart_txd, bits[k]);
      repeat (OS - 1) @(negedge clk);
      chk($sformatf("%s_b%0d_last", nm, k), uart_txd, bits[k]);
      @(negedge clk);
    end
  endtask

  initial begin
    int t0, r0, k, lat, per_t, per_b;
    logic [7:0] sp, b;
    logic bh;
    logic [7:0] exp_q[$];

    // reset-value vectors (0..8), then write/readback vectors (9..15)
    vecs[0]  = '{1'b0, ADDR_RCSTA, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, ADDR_TXREG, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, ADDR_RCREG, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, ADDR_TXSTA, 8'h00, 1'b1, 8'h02};
    vecs[4]  = '{1'b0, ADDR_SPBRG, 8'h00, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 9'h000,     8'h00, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 9'h118,     8'h00, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 9'h09A,     8'h00, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 9'h1FF,     8'h00, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, ADDR_TXSTA, 8'hFF, 1'b1, 8'h26};
    vecs[10] = '{1'b1, ADDR_RCSTA, 8'hFF, 1'b1, 8'h90};
    vecs[11] = '{1'b1, ADDR_RCSTA, 8'h6F, 1'b1, 8'h00};
    vecs[12] = '{1'b1, ADDR_SPBRG, 8'hA7, 1'b1, 8'hA7};
    vecs[13] = '{1'b1, 9'h000,     8'hFF, 1'b0, 8'h00};
    vecs[14] = '{1'b1, ADDR_TXSTA, 8'h00, 1'b1, 8'h02};
    vecs[15] = '{1'b1, ADDR_SPBRG, 8'h00, 1'b1, 8'h00};

    bus.addr = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    bus.addr = ADDR_TXSTA;
    #1;
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_txif", txif_strobe, 1'b0);
    chk("rst_rcif", rcif_strobe, 1'b0);
    chk("rst_data_out", bus.data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply_vecs(0, 15, "regs");

    // ---- single TX frame 0x55 at one tick per clock ----
    wr(ADDR_SPBRG, 8'h00);
    wr(ADDR_TXSTA, 8'h24);
    wr(ADDR_RCSTA, 8'h80);
    rd_chk("tx_trmt_idle", ADDR_TXSTA, 8'h26);
    t0 = n_txif;
    wr(ADDR_TXREG, 8'h55);
    @(negedge clk);
    chk("tx55_txif", txif_strobe, 1'b1);
    tx_frame(8'h55, "tx55");
    chk("tx55_idle_txd", uart_txd, 1'b1);
    rd_chk("tx55_trmt_done", ADDR_TXSTA, 8'h26);
    chk("tx55_txif_count", n_txif - t0, 1);

    // ---- back-to-back frames 0xA5, 0x3C ----
    t0 = n_txif;
    wr(ADDR_TXREG, 8'hA5);
    @(negedge clk);
    chk("b2b_txif1", txif_strobe, 1'b1);
    fork
      tx_frame(8'hA5, "b2b_a5");
      wr(ADDR_TXREG, 8'h3C);
    join
    chk("b2b_txif2", txif_strobe, 1'b1);
    rd_chk("b2b_trmt_busy", ADDR_TXSTA, 8'h24);
    tx_frame(8'h3C, "b2b_3c");
    rd_chk("b2b_trmt_done", ADDR_TXSTA, 8'h26);
    chk("b2b_txif_count", n_txif - t0, 2);

    // ---- receive 0xC3 ----
    wr(ADDR_RCSTA, 8'h90);
    r0 = n_rcif;
    send_byte(8'hC3, 1'b1, OS);
    chk("rx_c3_rcif", n_rcif - r0, 1);
    rd_chk("rx_c3_rcreg", ADDR_RCREG, 8'hC3);
    rd_chk("rx_c3_status", ADDR_RCSTA, 8'h90);
    pop_chk("rx_c3_pop", 8'hC3);
    rd_chk("rx_c3_last", ADDR_RCREG, 8'hC3);

    // ---- overrun ----
    r0 = n_rcif;
    send_byte(8'h11, 1'b1, OS);
    send_byte(8'h22, 1'b1, OS);
    chk("ovr_rcif", n_rcif - r0, 1);
    rd_chk("ovr_rcreg", ADDR_RCREG, 8'h11);
    rd_chk("ovr_oerr", ADDR_RCSTA, 8'h92);
    send_byte(8'h33, 1'b1, OS);
    chk("ovr_third_ignored", n_rcif - r0, 1);
    rd_chk("ovr_rcreg_kept", ADDR_RCREG, 8'h11);
    wr(ADDR_RCSTA, 8'h80);
    rd_chk("ovr_cleared", ADDR_RCSTA, 8'h80);
    wr(ADDR_RCSTA, 8'h90);
    pop_chk("ovr_pop", 8'h11);
    r0 = n_rcif;
    send_byte(8'h44, 1'b1, OS);
    chk("ovr_recover_rcif", n_rcif - r0, 1);
    rd_chk("ovr_recover_rcreg", ADDR_RCREG, 8'h44);
    pop_chk("ovr_recover_pop", 8'h44);

    // ---- framing error, then glitch rejection ----
    r0 = n_rcif;
    send_byte(8'h5A, 1'b0, OS);
    chk("ferr_rcif", n_rcif - r0, 1);
    rd_chk("ferr_rcreg", ADDR_RCREG, 8'h5A);
    rd_chk("ferr_flag", ADDR_RCSTA, 8'h94);
    pop_chk("ferr_pop", 8'h5A);
    r0 = n_rcif;
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (12 * OS) @(negedge clk);
    chk("glitch_no_rcif", n_rcif - r0, 0);

    // ---- receiver disabled: frames ignored, RCREG retained ----
    wr(ADDR_RCSTA, 8'h80);
    r0 = n_rcif;
    send_byte(8'h77, 1'b1, OS);
    chk("cren0_no_rcif", n_rcif - r0, 0);
    rd_chk("cren0_rcreg_kept", ADDR_RCREG, 8'h5A);

    // ---- randomized loopback at random baud settings ----
    wr(ADDR_RCSTA, 8'h90);
    loop_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      sp = 8'($urandom_range(0, 2));
      bh = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      per_t = (int'(sp) + 1) * (bh ? 1 : 4);
      per_b = OS * per_t;
      wr(ADDR_SPBRG, sp);
      wr(ADDR_TXSTA, bh ? 8'h24 : 8'h20);
      exp_q.push_back(b);
      wr(ADDR_TXREG, b);
      k = 0;
      while (!txif_strobe && k < 10) begin @(negedge clk); k++; end
      chk($sformatf("rnd%0d_txif_seen", it), txif_strobe, 1'b1);
      t0 = cyc;
      k = 0;
      while (!rcif_strobe && k < 12 * per_b) begin @(negedge clk); k++; end
      chk($sformatf("rnd%0d_rcif_seen", it), rcif_strobe, 1'b1);
      lat = cyc - t0;
      // stop-bit sample must fall inside the stop bit: [9, 10] bit periods
      chk($sformatf("rnd%0d_latency_%0d_per%0d", it, lat, per_b),
          (lat >= 9 * per_b) && (lat <= 10 * per_b), 1'b1);
      rd_chk($sformatf("rnd%0d_status", it), ADDR_RCSTA, 8'h90);
      pop_chk($sformatf("rnd%0d_byte", it), exp_q.pop_front());
      repeat (2 * per_b) @(negedge clk);
    end
    loop_en = 1'b0;

    // ---- reset in the middle of a TX byte ----
    wr(ADDR_SPBRG, 8'h00);
    wr(ADDR_TXSTA, 8'h24);
    wr(ADDR_TXREG, 8'h00);
    repeat (40) @(negedge clk);
    chk("midtx_txd_low", uart_txd, 1'b0);
    #2 rst_n = 1'b0;
    bus.addr = ADDR_TXSTA;
    #1;
    chk("midtx_rst_txd", uart_txd, 1'b1);
    chk("midtx_rst_data_out", bus.data_out, 8'h00);
    chk("midtx_rst_txif", txif_strobe, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = n_txif;
    r0 = n_rcif;
    repeat (50) @(negedge clk);
    chk("midtx_no_txif", n_txif - t0, 0);
    chk("midtx_no_rcif", n_rcif - r0, 0);
    chk("midtx_txd_idle", uart_txd, 1'b1);
    apply_vecs(0, 8, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_usart_peripheral.md
PIC_USART_PERIPHERAL -- requirements
Module: pic_usart_peripheral

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: RX/TX sub-bit ticks per bit.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: rxd metastability flops.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 addr  input  9  peripheral bus address from core.
REQ-006 wr_en  input  1  write strobe, qualifies addr/data_in.
REQ-007 rd_en  input  1  one-cycle read strobe; pops RCREG when addr hits it.
REQ-008 data_in  input  8  write data.
REQ-009 data_out  output  8  read data for hit address, else 0.
REQ-010 hit  output  1  addr matches any USART register (combinational).
REQ-011 txif_strobe  output  1  one-cycle pulse when TXREG moves into shifter.
REQ-012 rcif_strobe  output  1  one-cycle pulse when a received byte lands in RCREG.
REQ-013 uart_rxd  input  1  async serial in, idle high.
REQ-014 uart_txd  output  1  serial out, idle high.

Function
REQ-015 Register map SHALL be RCSTA 0x018, TXREG 0x019, RCREG 0x01A, TXSTA 0x098, SPBRG 0x099; other addresses inert.
REQ-016 TXSTA bits: [5] TXEN, [2] BRGH, [1] TRMT (RO, shifter empty); others read 0, writes ignored.
REQ-017 RCSTA bits: [7] SPEN, [4] CREN, [2] FERR (RO), [1] OERR (RO); others read 0.
REQ-018 Tick generator SHALL pulse once every (SPBRG+1)*(BRGH ? 1 : 4) clocks; bit period = OVERSAMPLE ticks.
REQ-019 SPBRG write SHALL reload the tick counter to 0 on the next cycle.
REQ-020 TX path: TXREG buffer + shift register; states IDLE, START, DATA(8, LSB first), STOP.
REQ-021 TXREG write while buffer full SHALL overwrite buffer contents (no error flag).
REQ-022 When SPEN&TXEN, shifter in IDLE and buffer full: load shifter next cycle, clear buffer, pulse txif_strobe, TRMT=0.
REQ-023 TRMT SHALL return to 1 at end of STOP bit if buffer empty; back-to-back bytes SHALL have no idle gap.
REQ-024 Clearing TXEN or SPEN SHALL abort TX: state IDLE, uart_txd=1, buffer cleared, TRMT=1.
REQ-025 RX path: states IDLE, START, DATA, STOP on synchronized rxd.
REQ-026 Falling edge in IDLE -> START; at tick OVERSAMPLE/2 line still low -> DATA, else IDLE (glitch reject).
REQ-027 Each data/stop bit sampled at its OVERSAMPLE/2 tick midpoint.
REQ-028 At STOP sample: if RCREG empty, load byte, set FERR=~stop_bit, pulse rcif_strobe; if full, discard byte, set OERR.
REQ-029 While OERR=1 receiver SHALL stay IDLE; OERR cleared only by CREN 1->0 write.
REQ-030 rd_en at RCREG SHALL return byte and mark RCREG empty same cycle; read when empty returns last value.
REQ-031 RX completion and RCREG pop in same cycle: pop first, then load new byte, no OERR.
REQ-032 CREN=0 or SPEN=0 SHALL force RX IDLE; RCREG contents retained.
REQ-033 uart_txd SHALL be 1 whenever SPEN=0.

Reset
REQ-034 rst_n low SHALL asynchronously clear all registers: SPBRG=0, TXSTA=0x02, RCSTA=0x00, RCREG empty, TX/RX IDLE.
REQ-035 During reset uart_txd=1, strobes=0, data_out=0; synchronizer flops reset to 1.
REQ-036 Reset mid-frame SHALL truncate frame; no strobe emitted on reset release.

Structure
REQ-037 Register addresses and TXSTA/RCSTA bit indices SHALL live in the shared peripheral memory-map package.
REQ-038 TX/RX state enumerations SHALL be typedefs in the same package.
REQ-039 Tick generator SHALL be one sub-module, usart_baud_gen.

Verification
REQ-040 SPBRG=0, BRGH=1, SPEN=TXEN=1, write TXREG=0x55 -> txif_strobe next cycle; txd 0,1,0,1,0,1,0,1,0,1 each 16 clocks.
REQ-041 Two TXREG writes 0xA5, 0x3C -> two txif_strobes, frames contiguous, TRMT=1 only after second stop bit.
REQ-042 CREN=1, inject frame 0xC3 at 16-clk bits -> rcif_strobe, RCREG=0xC3, FERR=0; rd_en pops it.
REQ-043 Inject 0x11 then 0x22 without reading -> RCREG=0x11, OERR=1, third frame ignored; CREN 1->0->1 clears OERR.
REQ-044 Frame with stop bit 0 -> FERR=1; 4-clock low glitch on idle rxd -> no strobe.
REQ-045 rst_n asserted mid-TX byte -> txd=1 immediately, TRMT=1, all registers at reset values.
